// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Lines hold four words; misses refill a whole line, stores always go to memory.
`timescale 1ns/1ps
module data_cache_controller #(
  parameter int unsigned address_size = 10,
  parameter int unsigned word_size    = 32,
  parameter int unsigned block_size   = 128,
  parameter int unsigned index_bits   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [address_size-1:0] cpu_address,
  input  logic [word_size-1:0]    cpu_data_in,
  output logic [word_size-1:0]    cpu_data_out,
  output logic                    stall,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [address_size-1:0] mem_address,
  output logic [word_size-1:0]    mem_data_out,
  input  logic                    mem_ready,
  input  logic [block_size-1:0]   mem_block
);

  localparam int unsigned TAG_W = address_size - 2 - index_bits;
  localparam int unsigned LINES = 1 << index_bits;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_MEM} state_e;

  state_e                  state_q, state_d;
  logic [address_size-1:0] addr_q, addr_d;
  logic [word_size-1:0]    data_q, data_d;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [block_size-1:0]   line_q [LINES];
  logic                    fill_en, upd_en;

  logic [1:0]            req_off, lat_off;
  logic [index_bits-1:0] req_idx, lat_idx;
  logic [TAG_W-1:0]      req_tag, lat_tag;
  logic                  req_hit, lat_hit;

  assign req_off = cpu_address[1:0];
  assign req_idx = cpu_address[index_bits+1:2];
  assign req_tag = cpu_address[address_size-1:index_bits+2];
  assign lat_off = addr_q[1:0];
  assign lat_idx = addr_q[index_bits+1:2];
  assign lat_tag = addr_q[address_size-1:index_bits+2];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  assign mem_address  = addr_q;
  assign mem_data_out = data_q;

  // Word 0 sits in the most significant slot of a line.
  function automatic logic [word_size-1:0] word_of(input logic [block_size-1:0] blk,
                                                  input logic [1:0] off);
    return blk[block_size-1-word_size*off -: word_size];
  endfunction

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    stall        = 1'b0;
    cpu_data_out = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    fill_en      = 1'b0;
    upd_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_write) begin
          stall   = 1'b1;
          addr_d  = cpu_address;
          data_d  = cpu_data_in;
          state_d = WRITE_MEM;
        end else if (cpu_read) begin
          if (req_hit) begin
            cpu_data_out = word_of(line_q[req_idx], req_off);
          end else begin
            stall   = 1'b1;
            addr_d  = cpu_address;
            state_d = READ_MISS;
          end
        end
      end
      READ_MISS: begin
        if (mem_ready) begin
          fill_en      = 1'b1;
          cpu_data_out = word_of(mem_block, lat_off);
          state_d      = IDLE;
        end else begin
          stall    = 1'b1;
          mem_read = 1'b1;
        end
      end
      WRITE_MEM: begin
        if (mem_ready) begin
          upd_en  = lat_hit;
          state_d = IDLE;
        end else begin
          stall     = 1'b1;
          mem_write = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // While reset is held the CPU request must not surface as a stall or a hit.
    if (rst) begin
      stall        = 1'b0;
      cpu_data_out = '0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      fill_en      = 1'b0;
      upd_en       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (fill_en) valid_q[lat_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_q[lat_idx] <= mem_block;
      tag_q[lat_idx]  <= lat_tag;
    end else if (upd_en) begin
      line_q[lat_idx][block_size-1-word_size*lat_off -: word_size] <= data_q;
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed bench for data_cache_controller with a fixed-latency memory model.
`timescale 1ns/1ps
module tb_data_cache_controller;

  localparam int AW = 10;
  localparam int WW = 32;
  localparam int BW = 128;
  localparam int IB = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_read, cpu_write;
  logic [AW-1:0] cpu_address;
  logic [WW-1:0] cpu_data_in, cpu_data_out;
  logic          stall, mem_read, mem_write, mem_ready;
  logic [AW-1:0] mem_address;
  logic [WW-1:0] mem_data_out;
  logic [BW-1:0] mem_block;
  logic          mdl_ready, stray_ready;
  logic [31:0]   mem [1024];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  data_cache_controller #(
    .address_size(AW),
    .word_size   (WW),
    .block_size  (BW),
    .index_bits  (IB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_address (cpu_address),
    .cpu_data_in (cpu_data_in),
    .cpu_data_out(cpu_data_out),
    .stall       (stall),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_data_out(mem_data_out),
    .mem_ready   (mem_ready),
    .mem_block   (mem_block)
  );

  assign mem_ready = mdl_ready | stray_ready;

  always_comb
    mem_block = {mem[{mem_address[9:2], 2'd0}], mem[{mem_address[9:2], 2'd1}],
                 mem[{mem_address[9:2], 2'd2}], mem[{mem_address[9:2], 2'd3}]};

  // Memory answers in the fourth cycle a request is seen, i.e. cycle 5 of a transaction.
  initial begin
    int   cnt;
    logic pend_wr;
    cnt = 0; pend_wr = 1'b0; mdl_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        cnt = 0; mdl_ready = 1'b0;
      end else if (mdl_ready) begin
        if (pend_wr) mem[mem_address] = mem_data_out;
        mdl_ready = 1'b0; cnt = 0;
      end else if (mem_read || mem_write) begin
        pend_wr = mem_write;
        cnt++;
        if (cnt == 4) mdl_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input string tag, input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [31:0] wd, input int exp_cyc, input logic [31:0] exp_rd);
    int   cyc;
    logic rd_seen, wr_seen, lat_ok;
    @(posedge clk); #1;
    cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_data_in = wd;
    cyc = 1; rd_seen = 1'b0; wr_seen = 1'b0; lat_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (cyc > 1) begin
        if (mem_address !== a) lat_ok = 1'b0;
        if (wr && mem_data_out !== wd) lat_ok = 1'b0;
      end
      if (mem_read)  rd_seen = 1'b1;
      if (mem_write) wr_seen = 1'b1;
      if (!stall || cyc >= 20) break;
      // Scramble CPU inputs while stalled; the latched request must govern.
      @(posedge clk); #1;
      cpu_address = a ^ 10'h3FF; cpu_data_in = ~wd;
      cyc++;
    end
    chk({tag, ".cycles"}, cyc, exp_cyc);
    if (rd && !wr) chk({tag, ".data"}, cpu_data_out, exp_rd);
    chk({tag, ".mem_read"}, {31'd0, rd_seen}, {31'd0, (!wr && exp_cyc > 1)});
    chk({tag, ".mem_write"}, {31'd0, wr_seen}, {31'd0, wr});
    if (exp_cyc > 1) chk({tag, ".latched"}, {31'd0, lat_ok}, 32'd1);
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
    stray_ready = 1'b0;
    rst = 1'b1; cpu_read = 1'b1; cpu_write = 1'b0;
    cpu_address = 10'h004; cpu_data_in = '0;

    @(negedge clk);
    chk("rst.stall",        {31'd0, stall},     32'd0);
    chk("rst.mem_read",     {31'd0, mem_read},  32'd0);
    chk("rst.mem_write",    {31'd0, mem_write}, 32'd0);
    chk("rst.mem_address",  {22'd0, mem_address}, 32'd0);
    chk("rst.mem_data_out", mem_data_out, 32'd0);
    chk("rst.cpu_data_out", cpu_data_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_read = 1'b0;

    xact("rd004_miss",  1, 0, 10'h004, 32'h0,         5, 32'hC0DE0004);
    xact("rd006_hit",   1, 0, 10'h006, 32'h0,         1, 32'hC0DE0006);
    xact("wr005",       0, 1, 10'h005, 32'h12345678,  5, 32'h0);
    xact("rd005_hit",   1, 0, 10'h005, 32'h0,         1, 32'h12345678);
    xact("wr204_miss",  0, 1, 10'h204, 32'hDEADBEEF,  5, 32'h0);
    xact("rd004_hit",   1, 0, 10'h004, 32'h0,         1, 32'hC0DE0004);
    xact("rd084_miss",  1, 0, 10'h084, 32'h0,         5, 32'hC0DE0084);
    xact("rd004_remiss",1, 0, 10'h004, 32'h0,         5, 32'hC0DE0004);
    xact("rdwr006",     1, 1, 10'h006, 32'h0BADF00D,  5, 32'h0);
    xact("rd006_upd",   1, 0, 10'h006, 32'h0,         1, 32'h0BADF00D);
    xact("rd007_hit",   1, 0, 10'h007, 32'h0,         1, 32'hC0DE0007);

    // Abort a read miss with reset in its second READ_MISS cycle.
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_address = 10'h010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort.pre_mem_read", {31'd0, mem_read}, 32'd1);
    rst = 1'b1; #1;
    chk("abort.stall",       {31'd0, stall},    32'd0);
    chk("abort.mem_read",    {31'd0, mem_read}, 32'd0);
    chk("abort.mem_address", {22'd0, mem_address}, 32'd0);
    cpu_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    stray_ready = 1'b1;
    @(posedge clk); #1;
    stray_ready = 1'b0;

    xact("rd010_after_abort", 1, 0, 10'h010, 32'h0, 5, 32'hC0DE0010);
    xact("rd004_after_rst",   1, 0, 10'h004, 32'h0, 5, 32'hC0DE0004);

    @(negedge clk);
    chk("mem005",  mem[10'h005], 32'h12345678);
    chk("mem204",  mem[10'h204], 32'hDEADBEEF);
    chk("mem006",  mem[10'h006], 32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
